// File: rtl/aurora_hls_frame_checker.sv
// Receive-side CRC-32 / length checker for the 64-bit Aurora RX stream tap.
// Emits one registered crc_valid/crc_pass_fail_n verdict per frame; never backpressures.
module aurora_hls_frame_checker #(
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_tvalid,
  input  logic        rx_tready,
  input  logic [63:0] rx_tdata,
  input  logic        rx_tlast,
  output logic        crc_valid,
  output logic        crc_pass_fail_n,
  output logic [15:0] frame_beats,
  output logic        oversize_err
);

  localparam int unsigned CNT_W    = 17;
  localparam int unsigned CRC_W    = 32;
  localparam logic [CRC_W-1:0] CRC_POLY = 32'hEDB88320;
  localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BODY     = 2'd1,
    ST_OVERSIZE = 2'd2
  } state_e;

  // Reflected CRC-32 over one beat, byte 0 bit 0 first on the wire.
  function automatic logic [CRC_W-1:0] crc32_d64(input logic [CRC_W-1:0] crc_in,
                                                 input logic [63:0]      data);
    logic [CRC_W-1:0] c;
    c = crc_in;
    for (int i = 0; i < 64; i++) begin
      c = {1'b0, c[CRC_W-1:1]} ^ (CRC_POLY & {CRC_W{c[0] ^ data[i]}});
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             crc_valid_q, crc_valid_d;
  logic             pass_q, pass_d;
  logic             over_q, over_d;
  logic [15:0]      beats_q, beats_d;

  logic             accept;
  logic [CRC_W-1:0] crc_next;
  logic [CNT_W-1:0] cnt_inc;

  assign accept   = rx_tvalid && rx_tready;
  assign crc_next = crc32_d64(crc_q, rx_tdata);
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    crc_valid_d = 1'b0;
    pass_d      = pass_q;
    over_d      = 1'b0;
    beats_d     = beats_q;
    if (accept) begin
      if (rx_tlast) begin
        // CRC register is still at its init value in IDLE, so empty frames compare to 0.
        crc_valid_d = 1'b1;
        over_d      = (state_q == ST_OVERSIZE);
        pass_d      = (state_q != ST_OVERSIZE) && ((crc_q ^ CRC_INIT) == rx_tdata[31:0]);
        beats_d     = cnt_q[16] ? 16'hFFFF : cnt_q[15:0];
        state_d     = ST_IDLE;
        crc_d       = CRC_INIT;
        cnt_d       = '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            crc_d   = crc_next;
            cnt_d   = CNT_W'(1);
            state_d = (MAX_CNT == '0) ? ST_OVERSIZE : ST_BODY;
          end
          ST_BODY: begin
            crc_d = crc_next;
            cnt_d = cnt_inc;
            if (cnt_inc > MAX_CNT) state_d = ST_OVERSIZE;
          end
          ST_OVERSIZE: begin
            cnt_d = cnt_inc;
          end
          default: begin
            state_d = ST_IDLE;
            crc_d   = CRC_INIT;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
      crc_valid_q <= 1'b0;
      pass_q      <= 1'b0;
      over_q      <= 1'b0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      crc_valid_q <= crc_valid_d;
      pass_q      <= pass_d;
      over_q      <= over_d;
      beats_q     <= beats_d;
    end
  end

  assign crc_valid       = crc_valid_q;
  assign crc_pass_fail_n = pass_q;
  assign oversize_err    = over_q;
  assign frame_beats     = beats_q;

endmodule

// File: tb/tb_aurora_hls_frame_checker.sv
// Directed bench for aurora_hls_frame_checker: per-cycle vector table plus
// hand-written multi-frame sequences with a byte-serial CRC-32 reference.
module tb_aurora_hls_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [63:0] rx_tdata;
  logic        rx_tlast;
  logic        crc_valid;
  logic        crc_pass_fail_n;
  logic [15:0] frame_beats;
  logic        oversize_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  aurora_hls_frame_checker #(.MAX_BEATS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_tvalid       (rx_tvalid),
    .rx_tready       (rx_tready),
    .rx_tdata        (rx_tdata),
    .rx_tlast        (rx_tlast),
    .crc_valid       (crc_valid),
    .crc_pass_fail_n (crc_pass_fail_n),
    .frame_beats     (frame_beats),
    .oversize_err    (oversize_err)
  );

  typedef struct {
    logic        rst_n;
    logic        v;
    logic        r;
    logic        last;
    logic [63:0] data;
    logic        e_valid;
    logic        e_pass;
    logic        e_over;
    logic [15:0] e_beats;
  } vec_t;

  vec_t vecs[20];

  // Byte-at-a-time reflected CRC-32 over a list of beats.
  function automatic logic [31:0] crc_model(input logic [63:0] beats[$]);
    logic [31:0] c;
    logic [63:0] b;
    c = 32'hFFFFFFFF;
    foreach (beats[k]) begin
      b = beats[k];
      for (int j = 0; j < 8; j++) begin
        c = c ^ {24'h0, b[8*j +: 8]};
        for (int t = 0; t < 8; t++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Drive one cycle at negedge; outputs are sampled 1ns after the following posedge.
  task automatic drive(input logic rst, input logic v, input logic r,
                       input logic [63:0] d, input logic l);
    @(negedge clk);
    rst_n = rst; rx_tvalid = v; rx_tready = r; rx_tdata = d; rx_tlast = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic ep,
                       input logic eo, input logic [15:0] eb);
    logic bad;
    n_vec++;
    bad = (crc_valid !== ev) || (oversize_err !== eo) || (frame_beats !== eb) ||
          (ev && (crc_pass_fail_n !== ep));
    if (bad) begin
      n_miss++;
      $display("FAIL %s: got valid=%b pass=%b over=%b beats=%0d, want valid=%b pass=%b over=%b beats=%0d",
               name, crc_valid, crc_pass_fail_n, oversize_err, frame_beats, ev, ep, eo, eb);
    end
  endtask

  int pulses = 0;
  int errs   = 0;

  // Sends n random payload beats then a tlast carrying the reference CRC (optionally corrupted).
  task automatic run_frame(input string name, input int n, input bit corrupt,
                           input logic ep, input logic eo, input logic [15:0] eb);
    logic [63:0] q[$];
    logic [63:0] d;
    logic [31:0] crc;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      q.push_back(d);
      drive(1'b1, 1'b1, 1'b1, d, 1'b0);
      // crc_valid must have dropped after any previous one-cycle pulse
      if (i == 0) check({name, "_nopulse"}, 1'b0, 1'b0, 1'b0, frame_beats);
    end
    crc = crc_model(q) ^ (corrupt ? 32'h1 : 32'h0);
    drive(1'b1, 1'b1, 1'b1, {32'hDEADBEEF, crc}, 1'b1);
    check(name, 1'b1, ep, eo, eb);
    if (crc_valid === 1'b1) begin
      pulses++;
      if (crc_pass_fail_n !== 1'b1) errs++;
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_tvalid = 1'b0; rx_tready = 1'b0; rx_tdata = '0; rx_tlast = 1'b0;

    //          rst  v    r    last data                      ev   ep   eo   beats
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,                   1'b0,1'b0,1'b0,16'd0};
    vecs[1]  = '{1'b1,1'b0,1'b1,1'b0,64'h0,                   1'b0,1'b0,1'b0,16'd0};
    vecs[2]  = '{1'b1,1'b1,1'b1,1'b1,64'h0,                   1'b1,1'b1,1'b0,16'd0};
    vecs[3]  = '{1'b1,1'b1,1'b1,1'b1,64'h1,                   1'b1,1'b0,1'b0,16'd0};
    vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,64'h0,                   1'b0,1'b0,1'b0,16'd0};
    vecs[5]  = '{1'b1,1'b1,1'b1,1'b1,64'hFFFF_FFFF_6522_DF69, 1'b1,1'b1,1'b0,16'd1};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,64'h0,                   1'b0,1'b0,1'b0,16'd1};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b1,64'h0000_0000_6522_DF68, 1'b1,1'b0,1'b0,16'd1};
    // stalls: tready low with a tlast beat held, then tvalid low
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,64'h0,                   1'b0,1'b0,1'b0,16'd1};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,64'h1234_5678_9ABC_DEF0, 1'b0,1'b0,1'b0,16'd1};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,64'hFFFF_FFFF_FFFF_FFFF, 1'b0,1'b0,1'b0,16'd1};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b1,64'h0,                   1'b0,1'b0,1'b0,16'd1};
    vecs[12] = '{1'b1,1'b0,1'b1,1'b1,64'h0,                   1'b0,1'b0,1'b0,16'd1};
    vecs[13] = '{1'b1,1'b0,1'b1,1'b0,64'h5555,                1'b0,1'b0,1'b0,16'd1};
    vecs[14] = '{1'b1,1'b1,1'b1,1'b1,64'h0000_0000_6522_DF69, 1'b1,1'b1,1'b0,16'd1};
    // reset mid-frame, with a tlast beat presented during reset
    vecs[15] = '{1'b1,1'b1,1'b1,1'b0,64'hA5A5,                1'b0,1'b0,1'b0,16'd1};
    vecs[16] = '{1'b1,1'b1,1'b1,1'b0,64'h5A5A,                1'b0,1'b0,1'b0,16'd1};
    vecs[17] = '{1'b0,1'b1,1'b1,1'b1,64'h0,                   1'b0,1'b0,1'b0,16'd0};
    vecs[18] = '{1'b1,1'b1,1'b1,1'b0,64'h0,                   1'b0,1'b0,1'b0,16'd0};
    vecs[19] = '{1'b1,1'b1,1'b1,1'b1,64'h0000_0000_6522_DF69, 1'b1,1'b1,1'b0,16'd1};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst_n, vecs[i].v, vecs[i].r, vecs[i].data, vecs[i].last);
      check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pass,
            vecs[i].e_over, vecs[i].e_beats);
    end

    // Length boundary with MAX_BEATS = 4: 5 beats oversize even with a correct CRC, 4 beats pass
    run_frame("oversize5", 5, 1'b0, 1'b0, 1'b1, 16'd5);
    run_frame("max4",      4, 1'b0, 1'b1, 1'b0, 16'd4);

    // Six good back-to-back frames then one corrupted frame
    pulses = 0;
    errs   = 0;
    for (int f = 0; f < 6; f++) run_frame($sformatf("b2b%0d", f), 1 + (f % 3), 1'b0, 1'b1, 1'b0, 16'(1 + (f % 3)));
    run_frame("b2b_bad", 2, 1'b1, 1'b0, 1'b0, 16'd2);
    drive(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
    check("b2b_tail", 1'b0, 1'b0, 1'b0, 16'd2);
    n_vec++;
    if (pulses != 7 || errs != 1) begin
      n_miss++;
      $display("FAIL frame_tally: got received=%0d errors=%0d, want received=7 errors=1", pulses, errs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
